// File: rtl/spi_keys_pkg.sv
// spi_keys_pkg: shared constants and layouts for the key-to-SPI event block.
//   - Command codes understood after the command byte of a transaction.
//   - Event byte layout {press, index} and status byte layout {ovf, count}.
//   - groups_f(): number of 8-bit snapshot groups needed for a key count.
package spi_keys_pkg;

  localparam logic [7:0] CMD_EVT_READ = 8'h80;
  localparam logic [7:0] CMD_CLEAR    = 8'h81;
  localparam logic [7:0] EVT_EMPTY    = 8'hFF;

  // Event byte: bit 7 = new key level (1 = pressed), bits 6:0 = key index.
  typedef struct packed {
    logic       press;
    logic [6:0] idx;
  } evt_t;

  // Status byte returned while the command byte is being clocked in.
  typedef struct packed {
    logic       ovf;
    logic [6:0] count;
  } status_t;

  function automatic int groups_f(input int num_keys);
    return (num_keys + 7) / 8;
  endfunction

endpackage

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: SPI mode-0 byte-level slave running entirely on clk_g_i.
//   clk_g_i, rst_g_i       : system clock, synchronous active-high reset
//   spi_clk_g_i / spi_mosi_g_i / spi_cs_g_i : raw asynchronous SPI pins
//   spi_miso_g_o           : MISO, high-Z while chip select is high
//   cs_fall, cs_rise       : one-clock pulses on synchronized CS edges
//   byte_done, rx_byte     : pulse on the 8th SCK rise, with the received byte
//   tx_load, tx_byte       : load the next byte to shift out on MISO
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_g_i,
  input  logic       rst_g_i,
  input  logic       spi_clk_g_i,
  input  logic       spi_mosi_g_i,
  input  logic       spi_cs_g_i,
  output logic       spi_miso_g_o,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  input  logic       tx_load,
  input  logic [7:0] tx_byte
);

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic                   sck_prev_reg;
  logic                   cs_prev_reg;
  logic                   active_reg;
  logic [2:0]             bit_cnt_reg;
  logic [6:0]             rx_shift_reg;
  logic [7:0]             tx_shift_reg;

  logic sck_s, mosi_s, cs_s, sck_rise, sck_fall;

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;
  assign cs_fall  = cs_prev_reg & ~cs_s;
  assign cs_rise  = ~cs_prev_reg & cs_s;

  assign byte_done = active_reg & ~cs_s & sck_rise & (bit_cnt_reg == 3'd7);
  assign rx_byte   = {rx_shift_reg, mosi_s};

  assign spi_miso_g_o = spi_cs_g_i ? 1'bz : tx_shift_reg[7];

  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      // CS history resets to "selected" so that a CS already low when reset
      // releases never looks like a fresh falling edge: a genuine high must
      // be seen first, which is what aborts a transaction cut by reset.
      cs_sync_reg   <= '0;
      sck_prev_reg  <= 1'b0;
      cs_prev_reg   <= 1'b0;
      active_reg    <= 1'b0;
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_clk_g_i};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi_g_i};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_g_i};
      sck_prev_reg  <= sck_s;
      cs_prev_reg   <= cs_s;

      if (cs_fall) begin
        active_reg  <= 1'b1;
        bit_cnt_reg <= '0;
      end else if (cs_rise) begin
        active_reg  <= 1'b0;
        bit_cnt_reg <= '0;
      end else if (active_reg && sck_rise) begin
        rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
      end

      // The falling edge right after the 8th rise must not shift: bit 7 of
      // the freshly loaded byte is already on MISO for the next first rise.
      if (tx_load) begin
        tx_shift_reg <= tx_byte;
      end else if (active_reg && sck_fall && (bit_cnt_reg != 3'd0)) begin
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_keys_evt.sv
// spi_keys_evt: exposes debounced keys and a press/release event FIFO over SPI.
//   clk_g_i, rst_g_i : system clock (>= 8x SCK), synchronous active-high reset
//   spi_*            : mode-0 SPI slave pins (MISO high-Z while CS high)
//   keys_i_g         : debounced key levels, 1 = pressed
//   key_irq_g_o      : high while events are queued or overflow is flagged
// A scanner walks one key per clock and queues {level, index} on change.
module spi_keys_evt import spi_keys_pkg::*; #(
  parameter int NUM_KEYS    = 61,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_g_i,
  input  logic                rst_g_i,
  input  logic                spi_clk_g_i,
  input  logic                spi_mosi_g_i,
  output logic                spi_miso_g_o,
  input  logic                spi_cs_g_i,
  input  logic [NUM_KEYS-1:0] keys_i_g,
  output logic                key_irq_g_o
);

  localparam int              GROUPS   = groups_f(NUM_KEYS);
  localparam int              GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]      GROUPS_B = 8'(GROUPS);
  localparam logic [GW-1:0]   LAST_GRP = GW'(GROUPS - 1);
  localparam logic [6:0]      LAST_KEY = 7'(NUM_KEYS - 1);
  localparam logic [6:0]      DEPTH_C  = 7'(FIFO_DEPTH);

  logic       cs_fall, cs_rise, byte_done, tx_load;
  logic [7:0] rx_byte, tx_byte;

  spi_byte_slave #(.SYNC_STAGES(SYNC_STAGES)) u_slave (
    .clk_g_i      (clk_g_i),
    .rst_g_i      (rst_g_i),
    .spi_clk_g_i  (spi_clk_g_i),
    .spi_mosi_g_i (spi_mosi_g_i),
    .spi_cs_g_i   (spi_cs_g_i),
    .spi_miso_g_o (spi_miso_g_o),
    .cs_fall      (cs_fall),
    .cs_rise      (cs_rise),
    .byte_done    (byte_done),
    .rx_byte      (rx_byte),
    .tx_load      (tx_load),
    .tx_byte      (tx_byte)
  );

  // Keys widened to the full 7-bit index space; unused indices read as 0.
  logic [127:0] keys_pad;
  assign keys_pad = {{(128 - NUM_KEYS){1'b0}}, keys_i_g};

  logic [GROUPS*8-1:0] snap_reg;
  logic [7:0]          snap_grp [GROUPS];
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_snap
    assign snap_grp[gi] = snap_reg[8*gi +: 8];
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [6:0]    count_reg;
  logic          ovf_reg;
  logic [127:0]  reported_reg;
  logic [6:0]    scan_idx_reg;
  logic          irq_reg;

  logic          first_reg, carried_reg, load_pend_reg, status_pend_reg;
  logic [7:0]    cmd_reg;
  logic [GW-1:0] grp_reg;

  logic    key_chg, fifo_full, do_clear, do_pop, do_push, set_ovf;
  evt_t    new_evt;
  status_t status;

  always_comb begin
    key_chg   = keys_pad[scan_idx_reg] != reported_reg[scan_idx_reg];
    fifo_full = (count_reg == DEPTH_C);
    do_clear  = byte_done & first_reg & (rx_byte == CMD_CLEAR);
    // Pop only the head that actually went out in the byte just completed.
    do_pop    = byte_done & ~first_reg & (cmd_reg == CMD_EVT_READ) & carried_reg;
    // A simultaneous pop frees a slot; a clear drops the push so the change
    // stays unreported and is queued again on a later pass.
    do_push   = key_chg & (~fifo_full | do_pop) & ~do_clear;
    set_ovf   = key_chg & fifo_full & ~do_pop & ~do_clear;
    new_evt   = '{press: keys_pad[scan_idx_reg], idx: scan_idx_reg};
    status    = '{ovf: ovf_reg, count: count_reg};
  end

  // Next MISO byte, computed in the cycle after cs_fall / byte_done so that
  // the command, group pointer and FIFO already reflect that event.
  always_comb begin
    tx_byte = 8'h00;
    if (status_pend_reg) begin
      tx_byte = status;
    end else if (cmd_reg < GROUPS_B) begin
      tx_byte = snap_grp[grp_reg];
    end else if (cmd_reg == CMD_EVT_READ) begin
      tx_byte = (count_reg == 7'd0) ? EVT_EMPTY : fifo_mem[rd_ptr_reg];
    end
  end

  assign tx_load     = load_pend_reg;
  assign key_irq_g_o = irq_reg;

  // Transaction control.
  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      snap_reg        <= '0;
      first_reg       <= 1'b0;
      carried_reg     <= 1'b0;
      load_pend_reg   <= 1'b0;
      status_pend_reg <= 1'b0;
      cmd_reg         <= 8'h00;
      grp_reg         <= '0;
    end else begin
      load_pend_reg   <= cs_fall | byte_done;
      status_pend_reg <= cs_fall;
      if (cs_fall) begin
        snap_reg    <= keys_pad[GROUPS*8-1:0];
        first_reg   <= 1'b1;
        carried_reg <= 1'b0;
      end else if (cs_rise) begin
        first_reg   <= 1'b0;
        carried_reg <= 1'b0;
      end else if (byte_done) begin
        first_reg   <= 1'b0;
        carried_reg <= 1'b0;
        if (first_reg) begin
          cmd_reg <= rx_byte;
          if (rx_byte < GROUPS_B) begin
            grp_reg <= rx_byte[GW-1:0];
          end
        end
      end else if (load_pend_reg && !status_pend_reg) begin
        if (cmd_reg < GROUPS_B) begin
          grp_reg <= (grp_reg == LAST_GRP) ? '0 : grp_reg + 1'b1;
        end
        carried_reg <= (cmd_reg == CMD_EVT_READ) && (count_reg != 7'd0);
      end
    end
  end

  // Change scanner and event FIFO bookkeeping.
  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      reported_reg <= '0;
      scan_idx_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      scan_idx_reg <= (scan_idx_reg == LAST_KEY) ? 7'd0 : scan_idx_reg + 7'd1;
      irq_reg      <= (count_reg != 7'd0) | ovf_reg;
      if (do_clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        ovf_reg    <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr_reg                 <= wr_ptr_reg + 1'b1;
          reported_reg[scan_idx_reg] <= keys_pad[scan_idx_reg];
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (set_ovf) begin
          ovf_reg <= 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count_reg <= count_reg + 7'd1;
          2'b01:   count_reg <= count_reg - 7'd1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk_g_i) begin
    if (do_push) begin
      fifo_mem[wr_ptr_reg] <= new_evt;
    end
  end

endmodule

// File: tb/tb_spi_keys_evt.sv
// tb_spi_keys_evt: directed bench for spi_keys_evt (NUM_KEYS=61, depth 16).
// SPI is bit-banged at SCK = clk/16; MISO is sampled just before each SCK rise.
module tb_spi_keys_evt;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sck  = 1'b0;
  logic        mosi = 1'b0;
  logic        cs   = 1'b1;
  logic [60:0] keys = '0;
  wire         miso;
  wire         irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   st_byte;
  logic [7:0]   rx_buf [32];
  logic [127:0] seen = '0;
  logic         got;

  typedef struct {
    logic [63:0] keys;
    logic [7:0]  cmd;
    logic [31:0] exp;   // four data bytes, first byte in bits 31:24
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  spi_keys_evt #(.NUM_KEYS(61), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk_g_i      (clk),
    .rst_g_i      (rst),
    .spi_clk_g_i  (sck),
    .spi_mosi_g_i (mosi),
    .spi_miso_g_o (miso),
    .spi_cs_g_i   (cs),
    .keys_i_g     (keys),
    .key_irq_g_o  (irq)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, required %02h", name, act, exp);
  endtask

  task automatic check_evt(input string name, input logic [7:0] e);
    logic ok;
    ok = e[7] && (e[6:0] >= 7'd10) && (e[6:0] <= 7'd29) && !seen[e[6:0]];
    n_checks++;
    if (ok) begin
      n_pass++;
      seen[e[6:0]] = 1'b1;
    end else begin
      $display("FAIL %s: got %02h, required unseen press event of key 10..29", name, e);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (8) @(negedge clk);
    r = miso;
    sck = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int n);
    logic [7:0] b;
    cs = 1'b0;
    repeat (10) @(negedge clk);
    spi_byte(cmd, b);
    st_byte = b;
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, b);
      rx_buf[i] = b;
    end
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    $display("txn cmd=%02h data_bytes=%0d status=%02h", cmd, n, st_byte);
  endtask

  // Several clear rounds so every change pending behind a full FIFO is
  // eventually reported and then discarded.
  task automatic flush();
    for (int r = 0; r < 5; r++) begin
      repeat (80) @(negedge clk);
      spi_txn(8'h81, 1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       r;

    vecs[0] = '{64'h1F23_4567_89AB_CDEF, 8'h00, 32'hEFCD_AB89};
    vecs[1] = '{64'h1F23_4567_89AB_CDEF, 8'h07, 32'h1FEF_CDAB};
    vecs[2] = '{64'h1F23_4567_89AB_CDEF, 8'h05, 32'h4523_1FEF};
    vecs[3] = '{64'h1F23_4567_89AB_CDEF, 8'h42, 32'h0000_0000};
    vecs[4] = '{64'h1F23_4567_89AB_CDEF, 8'h08, 32'h0000_0000};
    vecs[5] = '{64'h1F23_4567_89AB_CDEF, 8'h80, 32'hFFFF_FFFF};
    vecs[6] = '{64'h1FFF_FFFF_FFFF_FFFF, 8'h07, 32'h1FFF_FFFF};
    vecs[7] = '{64'h0000_0000_0000_0100, 8'h01, 32'h0100_0000};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset / idle read of every group.
    check8("reset_irq", {7'd0, irq}, 8'h00);
    spi_txn(8'h00, 8);
    check8("reset_status", st_byte, 8'h00);
    for (int i = 0; i < 8; i++) check8($sformatf("reset_grp%0d", i), rx_buf[i], 8'h00);

    // Single press of key 9: irq, then status, event, empty marker.
    keys[9] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 63 && !got; i++) begin
      @(negedge clk);
      got = irq;
    end
    check8("press9_irq_rise", {7'd0, got}, 8'h01);
    spi_txn(8'h80, 2);
    check8("press9_status", st_byte, 8'h01);
    check8("press9_evt", rx_buf[0], 8'h89);
    check8("press9_empty", rx_buf[1], 8'hFF);
    check8("press9_irq_fall", {7'd0, irq}, 8'h00);
    keys[9] = 1'b0;
    repeat (70) @(negedge clk);
    spi_txn(8'h80, 1);
    check8("release9_status", st_byte, 8'h01);
    check8("release9_evt", rx_buf[0], 8'h09);

    // Event byte aborted after 4 SCK edges must not pop the head.
    keys[3] = 1'b1;
    repeat (70) @(negedge clk);
    cs = 1'b0;
    repeat (10) @(negedge clk);
    spi_byte(8'h80, b);
    check8("abort_status", b, 8'h01);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    $display("txn cmd=80 aborted after 4 bits status=%02h", b);
    spi_txn(8'h80, 2);
    check8("after_abort_status", st_byte, 8'h01);
    check8("after_abort_evt", rx_buf[0], 8'h83);
    check8("after_abort_empty", rx_buf[1], 8'hFF);

    // Overflow: 20 changes into a 16-deep FIFO.
    keys[29:10] = '1;
    repeat (200) @(negedge clk);
    spi_txn(8'h80, 16);
    check8("ovf_status_full", st_byte, 8'h90);
    for (int i = 0; i < 16; i++) check_evt($sformatf("ovf_evt%0d", i), rx_buf[i]);
    spi_txn(8'h80, 5);
    check8("ovf_status_rest", st_byte, 8'h84);
    for (int i = 0; i < 4; i++) check_evt($sformatf("ovf_rest%0d", i), rx_buf[i]);
    check8("ovf_rest_empty", rx_buf[4], 8'hFF);
    spi_txn(8'h81, 1);
    check8("clear_status", st_byte, 8'h80);
    check8("clear_data", rx_buf[0], 8'h00);
    spi_txn(8'h42, 2);
    check8("post_clear_status", st_byte, 8'h00);
    check8("other_cmd_b0", rx_buf[0], 8'h00);
    check8("other_cmd_b1", rx_buf[1], 8'h00);
    check8("post_clear_irq", {7'd0, irq}, 8'h00);

    // Table of snapshot / command vectors, each from a clean FIFO.
    for (int v = 0; v < 8; v++) begin
      keys = vecs[v].keys[60:0];
      flush();
      check8($sformatf("vec%0d_irq", v), {7'd0, irq}, 8'h00);
      spi_txn(vecs[v].cmd, 4);
      check8($sformatf("vec%0d_status", v), st_byte, 8'h00);
      for (int i = 0; i < 4; i++)
        check8($sformatf("vec%0d_byte%0d", v, i), rx_buf[i], vecs[v].exp[31-8*i -: 8]);
    end

    // Keys change after CS fall: the reply still shows the CS-fall snapshot.
    keys = vecs[0].keys[60:0];
    flush();
    cs = 1'b0;
    repeat (10) @(negedge clk);
    spi_byte(8'h01, b);
    check8("snap_status", b, 8'h00);
    keys = vecs[6].keys[60:0];
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, b);
      rx_buf[i] = b;
    end
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    $display("txn cmd=01 keys changed mid-transaction status=00");
    check8("snap_grp1", rx_buf[0], 8'hCD);
    check8("snap_grp2", rx_buf[1], 8'hAB);
    check8("snap_grp3", rx_buf[2], 8'h89);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
